bsg_nonce_collector: RTL

- Downstream consumer of the target-check stage. Accepts one pass/fail verdict per hashed nonce and counts the attempts.
- Latches the first nonce whose double-SHA falls below target, then presents it to the host controller with a valid/yumi handshake.
- Also reports exhaustion when a programmable attempt limit is reached without a hit.

---
 rtl/bsg_nonce_collector.sv | 115 +++++++++++
 1 files changed

// File: rtl/bsg_nonce_collector.sv
// Nonce collector: counts pass/fail verdicts from the target-check stage.
// Captures the first hit, or reports exhaustion at a programmable limit, and hands the result to the host.
module bsg_nonce_collector #(
    parameter int nonce_width_p = 32,
    parameter int count_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [count_width_p-1:0] limit_i,
    input  logic                     v_i,
    input  logic                     data_i,
    input  logic [nonce_width_p-1:0] nonce_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic                     found_o,
    output logic [nonce_width_p-1:0] nonce_o,
    output logic [count_width_p-1:0] attempts_o,
    output logic                     busy_o,
    input  logic                     yumi_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                     state_q,    state_d;
    logic [count_width_p-1:0]   attempts_q, attempts_d;
    logic [count_width_p-1:0]   limit_q,    limit_d;
    logic [nonce_width_p-1:0]   nonce_q,    nonce_d;
    logic                       found_q,    found_d;

    logic                       accept;
    logic [count_width_p-1:0]   attempts_inc;
    logic                       limit_reached;

    // Handshake outputs depend on state alone, so v_i/data_i never reach them combinationally.
    assign ready_o    = (state_q == ST_RUN);
    assign busy_o     = (state_q == ST_RUN);
    assign v_o        = (state_q == ST_DONE);
    assign found_o    = found_q;
    assign nonce_o    = nonce_q;
    assign attempts_o = attempts_q;

    assign accept        = v_i && (state_q == ST_RUN);
    // Saturate rather than wrap so an unlimited search cannot alias a small count.
    assign attempts_inc  = (attempts_q == {count_width_p{1'b1}}) ? attempts_q
                                                                  : attempts_q + 1'b1;
    assign limit_reached = (limit_q != '0) && (attempts_inc == limit_q);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        limit_d    = limit_q;
        nonce_d    = nonce_q;
        found_d    = found_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    attempts_d = '0;
                    limit_d    = limit_i;
                    found_d    = 1'b0;
                end
            end

            ST_RUN: begin
                if (accept) begin
                    attempts_d = attempts_inc;
                    // A hit on the last permitted attempt still counts as a hit.
                    if (data_i) begin
                        nonce_d = nonce_i;
                        found_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (limit_reached) begin
                        found_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (yumi_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            attempts_q <= '0;
            limit_q    <= '0;
            nonce_q    <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            limit_q    <= limit_d;
            nonce_q    <= nonce_d;
            found_q    <= found_d;
        end
    end

endmodule
